// File: rtl/tabellone_morra.sv
// Scoreboard downstream of the Morra Cinese game FSM: per-game tallies, round history,
// cumulative game counts and a valid/ready summary record. Streak tracking under TABELLONE_SERIE_EN.
module tabellone_morra #(
  parameter int HIST_DEPTH = 8,
  parameter int GAME_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    INIZIO,
  input  logic [1:0]              MANCHE,
  input  logic [1:0]              PARTITA,
  output logic [4:0]              VINTE1,
  output logic [4:0]              VINTE2,
  output logic [4:0]              PAREGGI,
  output logic [4:0]              TOTALE,
  output logic [2*HIST_DEPTH-1:0] STORIA,
  output logic                    FINE,
  output logic [1:0]              ESITO,
  output logic [GAME_W-1:0]       PARTITE1,
  output logic [GAME_W-1:0]       PARTITE2,
  output logic [GAME_W-1:0]       PARTITEP,
  output logic                    REC_VALID,
  input  logic                    REC_READY,
  output logic [16:0]             REC_DATA,
  output logic                    REC_PERSO,
  output logic [2:0]              SERIE,
  output logic [1:0]              SERIE_DI
);

  typedef enum logic [1:0] {IDLE, GIOCO, CHIUSA} state_t;

  function automatic logic [4:0] sat_round(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  function automatic logic [GAME_W-1:0] sat_game(input logic [GAME_W-1:0] v);
    return (v == {GAME_W{1'b1}}) ? v : v + {{(GAME_W-1){1'b0}}, 1'b1};
  endfunction

  state_t                  state_q, state_d;
  logic [4:0]              vinte1_q, vinte1_d, vinte2_q, vinte2_d;
  logic [4:0]              pareggi_q, pareggi_d, totale_q, totale_d;
  logic [2*HIST_DEPTH-1:0] storia_q, storia_d;
  logic                    fine_q, fine_d;
  logic [1:0]              esito_q, esito_d;
  logic [GAME_W-1:0]       partite1_q, partite1_d, partite2_q, partite2_d;
  logic [GAME_W-1:0]       partitep_q, partitep_d;
  logic                    rec_valid_q, rec_valid_d, rec_perso_q, rec_perso_d;
  logic [16:0]             rec_data_q, rec_data_d;
  logic                    rec_load, rec_xfer;

  always_comb begin
    state_d     = state_q;
    vinte1_d    = vinte1_q;
    vinte2_d    = vinte2_q;
    pareggi_d   = pareggi_q;
    totale_d    = totale_q;
    storia_d    = storia_q;
    fine_d      = fine_q;
    esito_d     = esito_q;
    partite1_d  = partite1_q;
    partite2_d  = partite2_q;
    partitep_d  = partitep_q;
    rec_data_d  = rec_data_q;
    rec_valid_d = rec_valid_q;
    rec_perso_d = rec_perso_q;
    rec_load    = 1'b0;
    rec_xfer    = rec_valid_q & REC_READY;

    if (INIZIO) begin
      // New game wins over any same-cycle round or game result
      state_d   = GIOCO;
      vinte1_d  = '0;
      vinte2_d  = '0;
      pareggi_d = '0;
      totale_d  = '0;
      storia_d  = '0;
      fine_d    = 1'b0;
    end else if (state_q == GIOCO) begin
      if (MANCHE != 2'b00) begin
        totale_d = sat_round(totale_q);
        storia_d = {storia_q[2*HIST_DEPTH-3:0], MANCHE};
        case (MANCHE)
          2'b01:   vinte1_d  = sat_round(vinte1_q);
          2'b10:   vinte2_d  = sat_round(vinte2_q);
          default: pareggi_d = sat_round(pareggi_q);
        endcase
      end
      if (PARTITA != 2'b00) begin
        state_d = CHIUSA;
        fine_d  = 1'b1;
        esito_d = PARTITA;
        case (PARTITA)
          2'b01:   partite1_d = sat_game(partite1_q);
          2'b10:   partite2_d = sat_game(partite2_q);
          default: partitep_d = sat_game(partitep_q);
        endcase
        rec_load   = 1'b1;
        rec_data_d = {PARTITA, vinte1_d, vinte2_d, pareggi_d};
      end
    end

    // A load beats a same-edge transfer; only a load onto an untaken record is a loss
    if (rec_load) begin
      rec_valid_d = 1'b1;
      if (rec_valid_q && !rec_xfer) rec_perso_d = 1'b1;
    end else if (rec_xfer) begin
      rec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vinte1_q    <= '0;
      vinte2_q    <= '0;
      pareggi_q   <= '0;
      totale_q    <= '0;
      storia_q    <= '0;
      fine_q      <= 1'b0;
      esito_q     <= '0;
      partite1_q  <= '0;
      partite2_q  <= '0;
      partitep_q  <= '0;
      rec_valid_q <= 1'b0;
      rec_data_q  <= '0;
      rec_perso_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vinte1_q    <= vinte1_d;
      vinte2_q    <= vinte2_d;
      pareggi_q   <= pareggi_d;
      totale_q    <= totale_d;
      storia_q    <= storia_d;
      fine_q      <= fine_d;
      esito_q     <= esito_d;
      partite1_q  <= partite1_d;
      partite2_q  <= partite2_d;
      partitep_q  <= partitep_d;
      rec_valid_q <= rec_valid_d;
      rec_data_q  <= rec_data_d;
      rec_perso_q <= rec_perso_d;
    end
  end

`ifdef TABELLONE_SERIE_EN
  logic [2:0] serie_q, serie_d;
  logic [1:0] serie_di_q, serie_di_d;

  always_comb begin
    serie_d    = serie_q;
    serie_di_d = serie_di_q;
    if (INIZIO) begin
      serie_d    = '0;
      serie_di_d = '0;
    end else if (state_q == GIOCO) begin
      if (MANCHE == 2'b11) begin
        serie_d    = '0;
        serie_di_d = '0;
      end else if (MANCHE != 2'b00) begin
        if (serie_di_q == MANCHE) begin
          serie_d = (serie_q == 3'd7) ? serie_q : serie_q + 3'd1;
        end else begin
          serie_d    = 3'd1;
          serie_di_d = MANCHE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serie_q    <= '0;
      serie_di_q <= '0;
    end else begin
      serie_q    <= serie_d;
      serie_di_q <= serie_di_d;
    end
  end

  assign SERIE    = serie_q;
  assign SERIE_DI = serie_di_q;
`else
  assign SERIE    = '0;
  assign SERIE_DI = '0;
`endif

  assign VINTE1    = vinte1_q;
  assign VINTE2    = vinte2_q;
  assign PAREGGI   = pareggi_q;
  assign TOTALE    = totale_q;
  assign STORIA    = storia_q;
  assign FINE      = fine_q;
  assign ESITO     = esito_q;
  assign PARTITE1  = partite1_q;
  assign PARTITE2  = partite2_q;
  assign PARTITEP  = partitep_q;
  assign REC_VALID = rec_valid_q;
  assign REC_DATA  = rec_data_q;
  assign REC_PERSO = rec_perso_q;

endmodule
